// File: rtl/reg_file_scoreboard.sv
// Register file with writeback bypass plus a per-register pending-write
// scoreboard that flags decode hazards for long-latency producers.
module reg_file_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rf_rw_en_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [4:0]      r1_addr_i,
    input  logic [4:0]      r2_addr_i,
    output logic [XLEN-1:0] r1_data_o,
    output logic [XLEN-1:0] r2_data_o,
    input  logic            sb_set_i,
    input  logic [4:0]      sb_addr_i,
    input  logic            sb_flush_i,
    output logic            hazard_o,
    output logic [NREG-1:0] busy_o
);

    logic [XLEN-1:0] r_regs [1:NREG-1];
    logic [NREG-1:0] r_busy;

    logic            w_wr_en;
    logic            w_set_en;
    logic [31:0]     w_wr_onehot;
    logic [31:0]     w_set_onehot;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_busy_nxt;
    logic [31:0]     w_busy_eff;
    logic [XLEN-1:0] w_r1_stored;
    logic [XLEN-1:0] w_r2_stored;
    logic            w_byp1;
    logic            w_byp2;

    assign w_wr_en      = rf_rw_en_i && (rd_addr_i != 5'd0);
    assign w_set_en     = sb_set_i && (sb_addr_i != 5'd0);
    assign w_wr_onehot  = w_wr_en ? (32'd1 << rd_addr_i) : 32'd0;
    assign w_set_onehot = w_set_en ? (32'd1 << sb_addr_i) : 32'd0;
    assign w_clr_mask   = w_wr_onehot[NREG-1:0];
    assign w_set_mask   = w_set_onehot[NREG-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_wr_en && (rd_addr_i == 5'(i))) begin
                    r_regs[i] <= wb_data_i;
                end
            end
        end
    end

    // Set applied after clear so a new producer wins over the retiring one
    always_comb begin
        w_busy_nxt = '0;
        if (!sb_flush_i) begin
            w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        w_r1_stored = '0;
        w_r2_stored = '0;
        for (int i = 1; i < NREG; i++) begin
            if (r1_addr_i == 5'(i)) begin
                w_r1_stored = r_regs[i];
            end
            if (r2_addr_i == 5'(i)) begin
                w_r2_stored = r_regs[i];
            end
        end
    end

    assign w_byp1    = w_wr_en && (rd_addr_i == r1_addr_i);
    assign w_byp2    = w_wr_en && (rd_addr_i == r2_addr_i);
    assign r1_data_o = w_byp1 ? wb_data_i : w_r1_stored;
    assign r2_data_o = w_byp2 ? wb_data_i : w_r2_stored;

    // A register retiring this cycle is covered by the bypass path
    assign w_busy_eff = 32'(r_busy & ~w_clr_mask);

    assign hazard_o = w_busy_eff[r1_addr_i]
                    | w_busy_eff[r2_addr_i]
                    | (sb_set_i & w_busy_eff[sb_addr_i]);

    assign busy_o = r_busy;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic checked
// against an array-based register/pending model.
module tb_reg_file_scoreboard;

    logic        clk;
    logic        rst_ni;
    logic        rf_rw_en_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] wb_data_i;
    logic [4:0]  r1_addr_i;
    logic [4:0]  r2_addr_i;
    logic [31:0] r1_data_o;
    logic [31:0] r2_data_o;
    logic        sb_set_i;
    logic [4:0]  sb_addr_i;
    logic        sb_flush_i;
    logic        hazard_o;
    logic [31:0] busy_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    reg_file_scoreboard #(.XLEN(32), .NREG(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rf_rw_en_i (rf_rw_en_i),
        .rd_addr_i  (rd_addr_i),
        .wb_data_i  (wb_data_i),
        .r1_addr_i  (r1_addr_i),
        .r2_addr_i  (r2_addr_i),
        .r1_data_o  (r1_data_o),
        .r2_data_o  (r2_data_o),
        .sb_set_i   (sb_set_i),
        .sb_addr_i  (sb_addr_i),
        .sb_flush_i (sb_flush_i),
        .hazard_o   (hazard_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] rd,
                         input logic [31:0] wb, input logic [4:0] a1,
                         input logic [4:0] a2, input logic set,
                         input logic [4:0] sb, input logic fl);
        rf_rw_en_i = we;
        rd_addr_i  = rd;
        wb_data_i  = wb;
        r1_addr_i  = a1;
        r2_addr_i  = a2;
        sb_set_i   = set;
        sb_addr_i  = sb;
        sb_flush_i = fl;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0, 1'b0);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rf_rw_en_i && rd_addr_i == a) return wb_data_i;
        return m_regs[a];
    endfunction

    function automatic logic m_pending(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (rf_rw_en_i && rd_addr_i == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag);
        logic eh;
        eh = m_pending(r1_addr_i) | m_pending(r2_addr_i)
           | (sb_set_i & m_pending(sb_addr_i));
        chk({tag, ".r1"}, r1_data_o, m_read(r1_addr_i));
        chk({tag, ".r2"}, r2_data_o, m_read(r2_addr_i));
        chk({tag, ".hz"}, {31'd0, hazard_o}, {31'd0, eh});
        chk({tag, ".busy"}, busy_o, m_busy);
    endtask

    task automatic tick();
        if (rst_ni) begin
            if (rf_rw_en_i && rd_addr_i != 5'd0)
                m_regs[rd_addr_i] = wb_data_i;
            if (sb_flush_i) begin
                m_busy = '0;
            end else begin
                if (rf_rw_en_i && rd_addr_i != 5'd0)
                    m_busy[rd_addr_i] = 1'b0;
                if (sb_set_i && sb_addr_i != 5'd0)
                    m_busy[sb_addr_i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    initial begin
        logic [4:0] a;
        model_reset();
        rst_ni = 1'b0;
        idle(5'd3, 5'd0);
        #2;
        cmp("reset");
        chk("reset.hz0", {31'd0, hazard_o}, 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;

        // write x5, bypass same cycle, stored next cycle
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        cmp("x5_byp");
        chk("x5_byp_lit", r1_data_o, 32'hDEADBEEF);
        tick();
        idle(5'd5, 5'd0);
        #1;
        cmp("x5_rd");
        chk("x5_rd_lit", r1_data_o, 32'hDEADBEEF);

        // x0 hardwired, never busy
        drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        cmp("x0_wr");
        tick();
        idle(5'd0, 5'd0);
        #1;
        cmp("x0_rd");
        chk("x0_rd_lit", r1_data_o, 32'd0);
        chk("x0_busy", {31'd0, busy_o[0]}, 32'd0);

        // claim x7, hazard, retire with bypass
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
        #1;
        cmp("x7_set");
        tick();
        idle(5'd0, 5'd7);
        #1;
        cmp("x7_hz");
        chk("x7_hz_lit", {31'd0, hazard_o}, 32'd1);
        tick();
        drive(1'b1, 5'd7, 32'h55, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        cmp("x7_wb");
        chk("x7_wb_hz", {31'd0, hazard_o}, 32'd0);
        chk("x7_wb_r2", r2_data_o, 32'h55);
        tick();
        idle(5'd0, 5'd7);
        #1;
        cmp("x7_after");
        chk("x7_busy", {31'd0, busy_o[7]}, 32'd0);

        // set and clear same register: set wins
        drive(1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        #1;
        cmp("x9_both");
        tick();
        idle(5'd0, 5'd0);
        #1;
        cmp("x9_after");
        chk("x9_busy", {31'd0, busy_o[9]}, 32'd1);

        // claim x4, then set x3 while x4 retires
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        tick();
        drive(1'b1, 5'd4, 32'h44, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0);
        #1;
        cmp("x3x4");
        tick();
        idle(5'd3, 5'd4);
        #1;
        cmp("x3x4_after");
        chk("x3_busy", {31'd0, busy_o[3]}, 32'd1);
        chk("x4_busy", {31'd0, busy_o[4]}, 32'd0);

        // flush beats a same-cycle set; writeback still lands
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0);
        tick();
        drive(1'b1, 5'd6, 32'hA, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1);
        #1;
        cmp("flush");
        tick();
        idle(5'd6, 5'd1);
        #1;
        cmp("flush_after");
        chk("flush_busy", busy_o, 32'd0);
        chk("flush_x6", r1_data_o, 32'hA);

        // async reset mid-cycle with x8 busy and holding 1
        drive(1'b1, 5'd8, 32'h1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0);
        tick();
        idle(5'd8, 5'd0);
        #1;
        cmp("x8_pre");
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        cmp("arst");
        chk("arst_busy", busy_o, 32'd0);
        chk("arst_r1", r1_data_o, 32'd0);
        tick();
        drive(1'b1, 5'd8, 32'h77, 5'd8, 5'd9, 1'b1, 5'd9, 1'b0);
        #1;
        cmp("rst_byp");
        chk("rst_byp_lit", r1_data_o, 32'h77);
        tick();
        idle(5'd8, 5'd9);
        #1;
        cmp("rst_hold");
        rst_ni = 1'b1;
        tick();
        cmp("rst_rel");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), a, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0));
            #1;
            cmp("rand");
            tick();
        end
        idle(5'd0, 5'd0);
        #1;
        cmp("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
